// File: rtl/mul_norm_pack.sv
// FP16 post-multiply stage: aligns sign/exponent side data with the mantissa product,
// normalises, rounds to nearest-even, resolves specials and queues packed results.
module mul_norm_pack #(
  parameter int EXP_W      = 5,
  parameter int FRAC_W     = 10,
  parameter int BIAS       = 15,
  parameter int MAN_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign_a,
  input  logic                    in_sign_b,
  input  logic [EXP_W-1:0]        in_exp_a,
  input  logic [EXP_W-1:0]        in_exp_b,
  input  logic [15:0]             man_prod,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_result,
  output logic [2:0]              out_flags
);

  localparam int RW = 1 + EXP_W + FRAC_W;
  localparam int EW = EXP_W + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + MAN_LAT + 1) + 1;

  localparam logic [EXP_W-1:0]        EXP_ONES  = '1;
  localparam logic [FRAC_W-1:0]       QNAN_FRAC = FRAC_W'(1) << (FRAC_W - 1);
  localparam logic signed [EW-1:0]    E_BIAS    = EW'(BIAS);
  localparam logic signed [EW-1:0]    E_MAX     = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0]    E_ZERO    = '0;

  // mx is {m[14:0], sticky0}; returns {carry, frac} after round-to-nearest-even.
  function automatic logic [FRAC_W:0] round_rne(input logic [15:0] mx);
    logic [FRAC_W-1:0] frac;
    logic              g;
    logic              s;
    logic              up;
    frac = mx[14 -: FRAC_W];
    g    = mx[14-FRAC_W];
    s    = |(mx & ((16'd1 << (14 - FRAC_W)) - 16'd1));
    up   = g & (s | frac[0]);
    return {1'b0, frac} + {{FRAC_W{1'b0}}, up};
  endfunction

  // Returns {nan, ovf, unf, sign, exp, frac}; specials take priority over the product.
  function automatic logic [RW+2:0] pack_result(input logic             s,
                                                input logic [EXP_W-1:0] ea,
                                                input logic [EXP_W-1:0] eb,
                                                input logic [15:0]      p);
    logic                 n;
    logic [15:0]          mx;
    logic [FRAC_W:0]      rnd;
    logic signed [EW-1:0] e;
    logic [RW+2:0]        res;
    n   = p[15];
    mx  = n ? p : {p[14:0], 1'b0};
    rnd = round_rne(mx);
    e   = $signed(EW'(ea)) + $signed(EW'(eb)) - E_BIAS
        + $signed(EW'(n)) + $signed(EW'(rnd[FRAC_W]));
    if ((ea == '0 && eb == EXP_ONES) || (ea == EXP_ONES && eb == '0))
      res = {3'b100, 1'b0, EXP_ONES, QNAN_FRAC};
    else if (ea == EXP_ONES || eb == EXP_ONES)
      res = {3'b000, s, EXP_ONES, {FRAC_W{1'b0}}};
    else if (ea == '0 || eb == '0)
      res = {3'b000, s, {(EXP_W + FRAC_W){1'b0}}};
    else if (e >= E_MAX)
      res = {3'b010, s, EXP_ONES, {FRAC_W{1'b0}}};
    else if (e <= E_ZERO)
      res = {3'b001, s, {(EXP_W + FRAC_W){1'b0}}};
    else
      res = {3'b000, s, e[EXP_W-1:0], rnd[FRAC_W-1:0]};
    return res;
  endfunction

  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [CW-1:0]        w_inflight;
  logic [RW+2:0]        w_pack;

  logic [MAN_LAT:1]     r_vld_p;
  logic [MAN_LAT:1]     r_sign_p;
  logic [EXP_W-1:0]     r_ea_p [1:MAN_LAT];
  logic [EXP_W-1:0]     r_eb_p [1:MAN_LAT];

  logic [RW+2:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr;
  logic [AW-1:0]        r_rd;
  logic [CW-1:0]        r_cnt;

  assign w_accept = in_valid & in_ready;

  // Credit counts every result already committed downstream of the accept point.
  always_comb begin
    w_inflight = r_cnt;
    for (int k = 1; k <= MAN_LAT; k++)
      w_inflight = w_inflight + CW'(r_vld_p[k]);
  end

  assign in_ready = (w_inflight < CW'(FIFO_DEPTH));

  // Side pipe stages 1..MAN_LAT: free-running, no stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[1] <= w_accept;
      for (int k = 2; k <= MAN_LAT; k++)
        r_vld_p[k] <= r_vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    r_sign_p[1] <= in_sign_a ^ in_sign_b;
    r_ea_p[1]   <= in_exp_a;
    r_eb_p[1]   <= in_exp_b;
    for (int k = 2; k <= MAN_LAT; k++) begin
      r_sign_p[k] <= r_sign_p[k-1];
      r_ea_p[k]   <= r_ea_p[k-1];
      r_eb_p[k]   <= r_eb_p[k-1];
    end
  end

  // Last stage: product arrives, result formed combinationally and pushed on the next edge
  always_comb begin
    w_pack = pack_result(r_sign_p[MAN_LAT], r_ea_p[MAN_LAT], r_eb_p[MAN_LAT], man_prod);
  end

  assign w_push    = r_vld_p[MAN_LAT];
  assign out_valid = (r_cnt != '0);
  assign w_pop     = out_valid & out_ready;

  // Output FIFO stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_pack;
  end

  // Head is forced to zero when empty so outputs are clean out of reset.
  assign {out_flags, out_result} = out_valid ? r_mem[r_rd] : '0;

endmodule

// File: tb/tb_mul_norm_pack.sv
// Bench for mul_norm_pack: hand-computed vector table, a mantissa-latency model
// feeding man_prod, and an in-order scoreboard of expected packed results.
module tb_mul_norm_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign_a;
  logic        in_sign_b;
  logic [4:0]  in_exp_a;
  logic [4:0]  in_exp_b;
  logic [15:0] man_prod;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_flags;

  always #5 clk = ~clk;

  mul_norm_pack #(
    .EXP_W(5), .FRAC_W(10), .BIAS(15), .MAN_LAT(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign_a(in_sign_a), .in_sign_b(in_sign_b),
    .in_exp_a(in_exp_a), .in_exp_b(in_exp_b),
    .man_prod(man_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  typedef struct {
    logic        sa;
    logic        sb;
    logic [4:0]  ea;
    logic [4:0]  eb;
    logic [15:0] prod;
    logic [15:0] res;
    logic [2:0]  flg;
  } vec_t;

  localparam int NV = 19;
  vec_t        vecs [NV];
  logic [15:0] cur_prod;
  logic [18:0] cur_exp;
  logic [18:0] sbq [$];
  logic [15:0] prod_d1;
  logic [15:0] prod_d2;
  int          total = 0;
  int          bad   = 0;
  int          n_acc = 0;
  int          n_out = 0;
  logic        hold_prev = 1'b0;
  logic [18:0] prev_head;

  assign man_prod = prod_d2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mantissa multiplier model (registered product, MAN_LAT=2) plus scoreboard push.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_d1 <= 16'h0;
      prod_d2 <= 16'h0;
      sbq.delete();
    end else begin
      prod_d2 <= prod_d1;
      if (in_valid && in_ready) begin
        prod_d1 <= cur_prod;
        sbq.push_back(cur_exp);
        n_acc <= n_acc + 1;
      end else begin
        prod_d1 <= 16'h0;
      end
    end
  end

  always @(negedge clk) begin
    logic [18:0] e;
    if (rst_n && hold_prev && out_valid)
      chk("hold_stable", {13'd0, out_flags, out_result}, {13'd0, prev_head});
    hold_prev = rst_n && out_valid && !out_ready;
    prev_head = {out_flags, out_result};
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h want none", {out_flags, out_result});
      end else begin
        e = sbq.pop_front();
        chk("result", {16'd0, out_result}, {16'd0, e[15:0]});
        chk("flags", {29'd0, out_flags}, {29'd0, e[18:16]});
      end
    end
  end

  task automatic drive(input vec_t v);
    in_sign_a = v.sa;
    in_sign_b = v.sb;
    in_exp_a  = v.ea;
    in_exp_b  = v.eb;
    cur_prod  = v.prod;
    cur_exp   = {v.flg, v.res};
  endtask

  task automatic send(input vec_t v);
    int w;
    drive(v);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while ((sbq.size() != 0 || out_valid) && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    chk(name, {31'd0, (sbq.size() == 0 && !out_valid)}, 32'd1);
  endtask

  initial begin
    int a0;
    int snap;
    vecs[0]  = '{1'b0, 1'b0, 5'd15, 5'd15, 16'h4000, 16'h3C00, 3'b000};
    vecs[1]  = '{1'b0, 1'b0, 5'd15, 5'd15, 16'h9000, 16'h4080, 3'b000};
    vecs[2]  = '{1'b0, 1'b0, 5'd15, 5'd15, 16'h4008, 16'h3C00, 3'b000};
    vecs[3]  = '{1'b0, 1'b0, 5'd15, 5'd15, 16'h4018, 16'h3C02, 3'b000};
    vecs[4]  = '{1'b0, 1'b0, 5'd30, 5'd30, 16'h4000, 16'h7C00, 3'b010};
    vecs[5]  = '{1'b1, 1'b0, 5'd5,  5'd5,  16'h4000, 16'h8000, 3'b001};
    vecs[6]  = '{1'b0, 1'b0, 5'd0,  5'd31, 16'h5555, 16'h7E00, 3'b100};
    vecs[7]  = '{1'b1, 1'b0, 5'd31, 5'd20, 16'h5555, 16'hFC00, 3'b000};
    vecs[8]  = '{1'b0, 1'b0, 5'd0,  5'd20, 16'h5555, 16'h0000, 3'b000};
    vecs[9]  = '{1'b0, 1'b0, 5'd15, 5'd15, 16'h7FFF, 16'h4000, 3'b000};
    vecs[10] = '{1'b1, 1'b1, 5'd16, 5'd14, 16'hC000, 16'h4200, 3'b000};
    vecs[11] = '{1'b0, 1'b0, 5'd30, 5'd15, 16'h4000, 16'h7800, 3'b000};
    vecs[12] = '{1'b0, 1'b0, 5'd30, 5'd16, 16'h4000, 16'h7C00, 3'b010};
    vecs[13] = '{1'b0, 1'b0, 5'd1,  5'd14, 16'h4000, 16'h0000, 3'b001};
    vecs[14] = '{1'b1, 1'b0, 5'd30, 5'd15, 16'hFFFF, 16'hFC00, 3'b010};
    vecs[15] = '{1'b0, 1'b0, 5'd1,  5'd14, 16'h7FFF, 16'h0400, 3'b000};
    vecs[16] = '{1'b1, 1'b1, 5'd31, 5'd0,  16'h5555, 16'h7E00, 3'b100};
    vecs[17] = '{1'b0, 1'b1, 5'd20, 5'd0,  16'h5555, 16'h8000, 3'b000};
    vecs[18] = '{1'b0, 1'b0, 5'd15, 5'd15, 16'h5555, 16'h3D55, 3'b000};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", {16'd0, out_result}, 32'd0);
    chk("rst_out_flags", {29'd0, out_flags}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Accept->out_valid latency of three cycles with an empty FIFO.
    send(vecs[0]);
    chk("lat_cycle1", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_cycle2", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_cycle3", {31'd0, out_valid}, 32'd1);
    drain("drain_lat");

    // Back-to-back table vectors.
    for (int i = 1; i < NV; i++)
      send(vecs[i]);
    drain("drain_table");

    // Credit limit with a stalled consumer.
    out_ready = 1'b0;
    a0 = n_acc;
    for (int c = 0; c < 8; c++) begin
      drive(vecs[9 + ((n_acc - a0) & 3)]);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("credit_accepted", n_acc - a0, 32'd4);
    chk("credit_in_ready", {31'd0, in_ready}, 32'd0);
    chk("credit_out_valid", {31'd0, out_valid}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("drain_credit");
    chk("credit_in_ready_back", {31'd0, in_ready}, 32'd1);

    // Reset with two results buffered and two in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(vecs[1 + i]);
    chk("prereset_out_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    snap = n_out;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("postreset_outputs", n_out - snap, 32'd0);
    chk("postreset_out_valid", {31'd0, out_valid}, 32'd0);

    // Sanity after reset recovery.
    send(vecs[3]);
    drain("drain_recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
